flit_pkt_arbiter: RTL and testbench
===================================

Name: flit_pkt_arbiter

Overview:
- Shares one free-running 6-slot flit extractor among NUM_REQ packet sources.
- Each packet is one head flit, PKT_FLITS-2 body flits and one tail flit.
- Block keeps a slot counter phase-locked to the extractor's sampling counter (both reset by the same rst). It grants whole packets round-robin and streams the granted packet's flits so the head lands in slot 0.
- Sits between the router input ports and the extractor `i_flit`.

Parameters:
- NUM_REQ, 4, number of requesting sources
- PKT_FLITS, 6, flits per packet; must equal the extractor BUFFER_DEPTH
- FLIT_W, 16, flit width in bits
- SLOT_W, $clog2(PKT_FLITS), slot counter width
- IDLE_FLIT, 16'h0000, value driven when no packet flit is carried

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  NUM_REQ  per-source flit valid
- i_req_flit  in  NUM_REQ*FLIT_W  per-source flit; source k occupies bits [k*FLIT_W +: FLIT_W]
- o_req_ready  out  NUM_REQ  per-source flit accept, combinational
- o_flit  out  FLIT_W  registered flit to the extractor
- o_flit_valid  out  1  o_flit carries a granted packet flit
- o_slot  out  SLOT_W  current slot (mirrors the extractor counter)
- o_grant  out  NUM_REQ  one-hot owner of the packet in flight, registered
- o_pkt_start  out  1  pulse; o_flit holds a head flit (slot 0)
- o_underrun  out  1  pulse; granted source had no valid flit when one was due

Behaviour:
- Reset (async): slot=0, state IDLE, o_flit=IDLE_FLIT, o_flit_valid=0, o_grant=0, o_pkt_start=0, o_underrun=0, rr_ptr=0. Reset mid-packet aborts the packet; no resume.
- Slot counter: increments every cycle, wraps PKT_FLITS-1 -> 0 with no stall. It is never gated by requests.
- Arbitration happens only in cycles with slot==PKT_FLITS-1:
  - Search i_req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first valid source k wins.
  - o_req_ready[k]=1 combinationally, so k's head flit transfers on that edge.
  - At that edge: o_grant<=onehot(k), o_flit<=head, o_flit_valid<=1, o_pkt_start<=1, rr_ptr<=(k+1)%NUM_REQ, state<=STREAM.
  - If no source is valid: o_grant<=0, o_flit<=IDLE_FLIT, o_flit_valid<=0, state<=IDLE.
- STREAM, slots 0..PKT_FLITS-2:
  - o_req_ready = o_grant; at most one bit is ever set.
  - On each edge, o_flit<=granted i_req_flit and o_flit_valid<=1.
  - So the head appears during slot 0, body flits during slots 1..PKT_FLITS-2, and the tail during slot PKT_FLITS-1.
  - The extractor thus sees head/body/tail in buffer[0..PKT_FLITS-1].
- Underrun: if the granted source has valid=0 when ready=1, then on that edge o_flit<=IDLE_FLIT, o_flit_valid<=0 and o_underrun<=1 for one cycle. The grant is held to packet end and the slot is not re-issued.
- Back-to-back packets: the tail is loaded at the slot PKT_FLITS-2 edge. Arbitration in the slot PKT_FLITS-1 cycle then loads the next head, giving 100% slot utilisation.
- o_req_ready is 0 for all non-granted sources in every cycle. A source must present a packet's flits in order, one per accepted beat.
- Latency: a request raised in slot j appears at the output at slot 0 of the next frame. The worst case is (NUM_REQ-1) full frames of wait.
- Outputs other than o_req_ready and o_slot are registered. o_slot is the counter register.

Optional Feature:
- Macro FLIT_ARB_STATS_EN.
- Defined: extra output o_pkt_cnt [NUM_REQ*16-1:0] holds per-source 16-bit counters of granted packets. Each counter increments on its head grant edge, saturates at 16'hFFFF and resets to 0.
- Undefined: port and counters absent; all other behaviour is identical.

Decomposition:
- Package flit_pkg holds:
  - FLIT_W, PKT_FLITS, IDLE_FLIT
  - typedef flit_t (logic [FLIT_W-1:0])
  - enum arb_state_e {IDLE, STREAM}
- Sub-module rr_pick: combinational round-robin search, inputs valid vector and pointer, outputs one-hot pick and any-valid.

Test Plan:
- Single source 0 holds valid with flits 16'hA000..16'hA005 → o_pkt_start in slot 0. o_flit shows A000..A005 in slots 0..5, o_grant=4'b0001, extractor done with head=A000 and tail=A005.
- Sources 0..3 all valid continuously → grants rotate 0,1,2,3,0 on consecutive frames, with no IDLE frames between them.
- Source 2 raises valid in slot 3 → grant at the slot-5 edge; head appears in the next slot 0, not earlier.
- Source 1 drops valid in slot 2 of its packet → o_flit=0000 in slot 3, o_underrun pulses once, grant is held through slot 5, and the next frame is arbitrated normally.
- Reset asserted in slot 3 of a packet → all outputs 0 immediately; after release, slot=0 and the packet does not resume.
- With FLIT_ARB_STATS_EN, 3 packets from source 3 → o_pkt_cnt[63:48]=3 and the other counters stay 0.

Source files
------------

// File: rtl/flit_pkg.sv
// Shared constants, flit type and arbiter state encoding for the flit packet arbiter.
package flit_pkg;
  localparam int FLIT_W    = 16;
  localparam int PKT_FLITS = 6;
  localparam logic [FLIT_W-1:0] IDLE_FLIT = 16'h0000;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    IDLE,
    STREAM
  } arb_state_e;
endpackage

// File: rtl/flit_pkt_arbiter_if.sv
// Bus between the packet sources, the arbiter and the slot extractor.
// master: arbiter side; slave: sources/extractor side.
interface flit_pkt_arbiter_if
  import flit_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int FLIT_W    = flit_pkg::FLIT_W,
  parameter int PKT_FLITS = flit_pkg::PKT_FLITS,
  parameter int SLOT_W    = $clog2(PKT_FLITS)
);
  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ*FLIT_W-1:0] i_req_flit;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic [FLIT_W-1:0]         o_flit;
  logic                      o_flit_valid;
  logic [SLOT_W-1:0]         o_slot;
  logic [NUM_REQ-1:0]        o_grant;
  logic                      o_pkt_start;
  logic                      o_underrun;

  modport master (
    input  i_req_valid, i_req_flit,
    output o_req_ready, o_flit, o_flit_valid, o_slot, o_grant, o_pkt_start, o_underrun
  );

  modport slave (
    output i_req_valid, i_req_flit,
    input  o_req_ready, o_flit, o_flit_valid, o_slot, o_grant, o_pkt_start, o_underrun
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: one-hot pick of the first valid request at or after ptr.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             any
);
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N);
      if (!found && valid[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |valid;
endmodule

// File: rtl/flit_pkt_arbiter.sv
// Round-robin whole-packet arbiter feeding a free-running slot extractor (head lands in slot 0).
// Optional per-source granted-packet counters: define FLIT_ARB_STATS_EN.
module flit_pkt_arbiter
  import flit_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PKT_FLITS = flit_pkg::PKT_FLITS,
  parameter int FLIT_W    = flit_pkg::FLIT_W,
  parameter int SLOT_W    = $clog2(PKT_FLITS),
  parameter logic [FLIT_W-1:0] IDLE_FLIT = flit_pkg::IDLE_FLIT
) (
  input  logic clk,
  input  logic rst,
  flit_pkt_arbiter_if.master bus
`ifdef FLIT_ARB_STATS_EN
  , output logic [NUM_REQ*16-1:0] o_pkt_cnt
`endif
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PKT_FLITS - 1);

  arb_state_e         state, state_next;
  logic [SLOT_W-1:0]  slot;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_next, pick_idx;
  logic [NUM_REQ-1:0] grant, grant_next, pick, ready;
  logic               any_valid, arb_slot;
  logic [FLIT_W-1:0]  flit, flit_next, pick_flit, grant_flit;
  logic               flit_valid, flit_valid_next;
  logic               pkt_start, pkt_start_next;
  logic               underrun, underrun_next;

  assign arb_slot = (slot == LAST_SLOT);

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .valid (bus.i_req_valid),
    .ptr   (rr_ptr),
    .pick  (pick),
    .any   (any_valid)
  );

  always_comb begin
    pick_flit  = '0;
    grant_flit = '0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) begin
        pick_flit = bus.i_req_flit[k*FLIT_W +: FLIT_W];
        pick_idx  = PTR_W'(k);
      end
      if (grant[k]) grant_flit = bus.i_req_flit[k*FLIT_W +: FLIT_W];
    end
  end

  // The last slot of each frame arbitrates and loads the next head; earlier slots stream the owner.
  always_comb begin
    state_next      = state;
    rr_ptr_next     = rr_ptr;
    grant_next      = grant;
    flit_next       = IDLE_FLIT;
    flit_valid_next = 1'b0;
    pkt_start_next  = 1'b0;
    underrun_next   = 1'b0;
    ready           = '0;
    if (arb_slot) begin
      ready = pick;
      if (any_valid) begin
        state_next      = STREAM;
        grant_next      = pick;
        flit_next       = pick_flit;
        flit_valid_next = 1'b1;
        pkt_start_next  = 1'b1;
        rr_ptr_next     = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end else begin
        state_next = IDLE;
        grant_next = '0;
      end
    end else if (state == STREAM) begin
      ready = grant;
      if (|(grant & bus.i_req_valid)) begin
        flit_next       = grant_flit;
        flit_valid_next = 1'b1;
      end else begin
        underrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot       <= '0;
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      flit       <= IDLE_FLIT;
      flit_valid <= 1'b0;
      pkt_start  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      slot       <= arb_slot ? '0 : slot + 1'b1;
      state      <= state_next;
      rr_ptr     <= rr_ptr_next;
      grant      <= grant_next;
      flit       <= flit_next;
      flit_valid <= flit_valid_next;
      pkt_start  <= pkt_start_next;
      underrun   <= underrun_next;
    end
  end

`ifdef FLIT_ARB_STATS_EN
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (arb_slot && pick[k] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign o_pkt_cnt[k*16 +: 16] = cnt;
  end
`endif

  assign bus.o_req_ready  = ready;
  assign bus.o_flit       = flit;
  assign bus.o_flit_valid = flit_valid;
  assign bus.o_slot       = slot;
  assign bus.o_grant      = grant;
  assign bus.o_pkt_start  = pkt_start;
  assign bus.o_underrun   = underrun;
endmodule

// File: tb/tb_flit_pkt_arbiter.sv
// Self-checking bench for flit_pkt_arbiter: directed steps plus random sources checked against a frame-level model.
// Define FLIT_ARB_STATS_EN to also check the per-source packet counters.
module tb_flit_pkt_arbiter;
  import flit_pkg::*;

  localparam int N   = 4;
  localparam int P   = PKT_FLITS;
  localparam int LOG = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  flit_pkt_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef FLIT_ARB_STATS_EN
  logic [N*16-1:0] pkt_cnt;
`endif

  flit_pkt_arbiter #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FLIT_ARB_STATS_EN
    , .o_pkt_cnt (pkt_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  flit_t pkt [N][P];
  int    idx [N];
  bit    active [N];
  bit    drop [N];
  int    left [N];
  int    gen_pct = 0;

  // Frame-level model: each frame is either one whole winning packet or idle.
  bit           model_en = 1'b1;
  int           cyc = 0;
  int           ptr_m = 0;
  flit_t        exp_flit [P];
  bit           exp_valid [P];
  logic [N-1:0] exp_grant = '0;
  int           win_q [$];
  int           head_cyc = -1;

  flit_t        flit_log [LOG];
  logic         v_log [LOG];
  logic         u_log [LOG];
  logic         st_log [LOG];
  logic [N-1:0] g_log [LOG];
  logic [N-1:0] r_log [LOG];

  flit_t head2;
  int    cnt;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply_stimulus();
    for (int k = 0; k < N; k++) begin
      bus.i_req_valid[k] = active[k] && !drop[k];
      bus.i_req_flit[k*FLIT_W +: FLIT_W] = active[k] ? pkt[k][idx[k]] : flit_t'($urandom);
    end
  endtask

  task automatic bfm_step(input logic [N-1:0] acc);
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        idx[k]++;
        if (idx[k] == P) active[k] = 1'b0;
      end
      if (!active[k] && left[k] > 0 && int'($urandom_range(99)) < gen_pct) begin
        for (int j = 0; j < P; j++) pkt[k][j] = flit_t'($urandom);
        idx[k]    = 0;
        active[k] = 1'b1;
        left[k]--;
      end
    end
    apply_stimulus();
  endtask

  task automatic cycle();
    logic [N-1:0] acc, rdy_exp;
    logic [5:0]   li;
    int s, win;
    @(negedge clk);
    s = cyc % P;
    if (cyc < LOG) begin
      li = 6'(cyc);
      flit_log[li] = bus.o_flit;
      v_log[li]    = bus.o_flit_valid;
      u_log[li]    = bus.o_underrun;
      st_log[li]   = bus.o_pkt_start;
      g_log[li]    = bus.o_grant;
      r_log[li]    = bus.o_req_ready;
    end
    if (bus.o_pkt_start === 1'b1 && head_cyc < 0) head_cyc = cyc;
    win = -1;
    if (s == P - 1)
      for (int i = 0; i < N; i++)
        if (win < 0 && active[(ptr_m + i) % N] && !drop[(ptr_m + i) % N]) win = (ptr_m + i) % N;
    if (model_en) begin
      rdy_exp = '0;
      if (s == P - 1) begin
        if (win >= 0) rdy_exp = N'(1) << win;
      end else begin
        rdy_exp = exp_grant;
      end
      check_output("slot", 64'(bus.o_slot), 64'(s));
      check_output("flit", 64'(bus.o_flit), 64'(exp_flit[s]));
      check_output("flit_valid", 64'(bus.o_flit_valid), 64'(exp_valid[s]));
      check_output("grant", 64'(bus.o_grant), 64'(exp_grant));
      check_output("pkt_start", 64'(bus.o_pkt_start), 64'(s == 0 && exp_valid[0]));
      check_output("underrun", 64'(bus.o_underrun), 64'(0));
      check_output("ready", 64'(bus.o_req_ready), 64'(rdy_exp));
    end
    if (s == P - 1) begin
      if (win >= 0) begin
        exp_grant = N'(1) << win;
        for (int j = 0; j < P; j++) begin
          exp_flit[j]  = pkt[win][j];
          exp_valid[j] = 1'b1;
        end
        ptr_m = (win + 1) % N;
        win_q.push_back(win);
      end else begin
        exp_grant = '0;
        for (int j = 0; j < P; j++) begin
          exp_flit[j]  = IDLE_FLIT;
          exp_valid[j] = 1'b0;
        end
      end
    end
    acc = bus.i_req_valid & bus.o_req_ready;
    @(posedge clk);
    #1;
    cyc++;
    bfm_step(acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      active[k] = 1'b0;
      drop[k]   = 1'b0;
      left[k]   = 0;
      idx[k]    = 0;
    end
    gen_pct = 0;
    apply_stimulus();
    #2;
    check_output("rst_slot", 64'(bus.o_slot), 64'(0));
    check_output("rst_flit", 64'(bus.o_flit), 64'(IDLE_FLIT));
    check_output("rst_valid", 64'(bus.o_flit_valid), 64'(0));
    check_output("rst_grant", 64'(bus.o_grant), 64'(0));
    check_output("rst_start", 64'(bus.o_pkt_start), 64'(0));
    check_output("rst_underrun", 64'(bus.o_underrun), 64'(0));
    check_output("rst_ready", 64'(bus.o_req_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc       = 0;
    ptr_m     = 0;
    exp_grant = '0;
    head_cyc  = -1;
    model_en  = 1'b1;
    win_q.delete();
    for (int j = 0; j < P; j++) begin
      exp_flit[j]  = IDLE_FLIT;
      exp_valid[j] = 1'b0;
    end
  endtask

  initial begin
    // Single source 0 packet A000..A005
    do_reset();
    for (int j = 0; j < P; j++) pkt[0][j] = flit_t'(16'hA000 + j);
    idx[0] = 0;
    active[0] = 1'b1;
    apply_stimulus();
    repeat (12) cycle();
    check_output("a_start", 64'(st_log[6]), 64'(1));
    check_output("a_head", 64'(flit_log[6]), 64'(16'hA000));
    check_output("a_body", 64'(flit_log[8]), 64'(16'hA002));
    check_output("a_tail", 64'(flit_log[11]), 64'(16'hA005));
    check_output("a_grant", 64'(g_log[9]), 64'(4'b0001));

    // All sources continuously valid: grants rotate with no idle frame
    do_reset();
    for (int k = 0; k < N; k++) left[k] = 1000;
    gen_pct = 100;
    bfm_step('0);
    repeat (30) cycle();
    check_output("rot_count", 64'(win_q.size()), 64'(5));
    for (int i = 0; i < 5; i++) check_output("rot_order", 64'(win_q[i]), 64'(i % N));
    cnt = 0;
    for (int c = 6; c < 30; c++) if (v_log[c] === 1'b1) cnt++;
    check_output("rot_full", 64'(cnt), 64'(24));

    // Random traffic checked cycle by cycle against the frame model
    gen_pct = 30;
    repeat (300) cycle();

    // Source 2 raises valid in slot 3: head appears in the next slot 0
    do_reset();
    repeat (3) cycle();
    left[2] = 1;
    gen_pct = 100;
    bfm_step('0);
    head2 = pkt[2][0];
    repeat (10) cycle();
    check_output("late_ready", 64'(r_log[5]), 64'(4'b0100));
    check_output("late_no_early", 64'(v_log[5]), 64'(0));
    check_output("late_head_cyc", 64'(head_cyc), 64'(6));
    check_output("late_head", 64'(flit_log[6]), 64'(head2));
    check_output("late_grant", 64'(g_log[6]), 64'(4'b0100));

    // Source 1 drops valid in slot 2 of its packet
    do_reset();
    model_en = 1'b0;
    for (int j = 0; j < P; j++) pkt[1][j] = flit_t'(16'hB000 + j);
    active[1] = 1'b1;
    apply_stimulus();
    while (cyc < 8) cycle();
    drop[1] = 1'b1;
    apply_stimulus();
    cycle();
    drop[1] = 1'b0;
    apply_stimulus();
    while (cyc < 11) cycle();
    active[1] = 1'b0;
    for (int j = 0; j < P; j++) pkt[3][j] = flit_t'(16'hC000 + j);
    idx[3] = 0;
    active[3] = 1'b1;
    apply_stimulus();
    while (cyc < 18) cycle();
    check_output("u_before", 64'(flit_log[8]), 64'(16'hB002));
    check_output("u_flit", 64'(flit_log[9]), 64'(IDLE_FLIT));
    check_output("u_valid", 64'(v_log[9]), 64'(0));
    check_output("u_pulse", 64'(u_log[9]), 64'(1));
    cnt = 0;
    for (int c = 0; c < 18; c++) if (u_log[c] === 1'b1) cnt++;
    check_output("u_once", 64'(cnt), 64'(1));
    check_output("u_resume", 64'(flit_log[10]), 64'(16'hB003));
    check_output("u_held", 64'(g_log[11]), 64'(4'b0010));
    check_output("u_next_grant", 64'(g_log[12]), 64'(4'b1000));
    check_output("u_next_head", 64'(flit_log[12]), 64'(16'hC000));

    // Reset in slot 3 of a packet: outputs clear at once, packet does not resume
    do_reset();
    for (int j = 0; j < P; j++) pkt[0][j] = flit_t'(16'hD000 + j);
    active[0] = 1'b1;
    apply_stimulus();
    while (cyc < 9) cycle();
    check_output("mid_in_flight", 64'(v_log[8]), 64'(1));
    do_reset();
    repeat (12) cycle();
    cnt = 0;
    for (int c = 0; c < 12; c++) if (v_log[c] !== 1'b0 || g_log[c] !== '0) cnt++;
    check_output("mid_no_resume", 64'(cnt), 64'(0));

`ifdef FLIT_ARB_STATS_EN
    // Three packets from source 3
    do_reset();
    check_output("cnt_reset", 64'(pkt_cnt), 64'(0));
    left[3] = 3;
    gen_pct = 100;
    bfm_step('0);
    repeat (30) cycle();
    check_output("cnt_src3", 64'(pkt_cnt[63:48]), 64'(3));
    check_output("cnt_others", 64'(pkt_cnt[47:0]), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
